ysyx_25060170_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the single-issue NPC core. It steps the IFU → IDU → EXU → LSU → WB datapath one instruction at a time. It drives the instruction fetch and data memory handshakes, the instruction-register latch, the register-file write enable and the PC update. It also stops the core on ebreak, illegal opcode or bus timeout.

---
 rtl/ysyx_25060170_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ysyx_25060170_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_seq_ctrl.sv
// ============================================================================
// Module   : ysyx_25060170_seq_ctrl
// Brief    : Multi-cycle IFU/IDU/EXU/LSU/WB sequencer with halt/illegal/timeout
//            stops. Optional perf counters behind `SEQ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25060170_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_rvalid,
  output logic        inst_we,
  input  logic [6:0]  opcode,
  input  logic [11:0] sys_imm12,
  input  logic        br_taken,
  output logic        dmem_req,
  output logic        dmem_wen,
  input  logic        dmem_rvalid,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        halt,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_o,
  output logic [31:0] perf_cycle,
  output logic [31:0] perf_instret
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_JUMP   = 3'd4;
  localparam logic [2:0] C_SYS    = 3'd5;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [2:0]      state_q, state_d;
  logic [2:0]      cls_q, cls_d;
  logic            br_q, br_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            halt_q, halt_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;
  logic [2:0]      dec_cls;
  logic            dec_ok;
  logic            to_expired;

  always_comb begin
    dec_cls = C_ALU;
    dec_ok  = 1'b1;
    case (opcode)
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111: dec_cls = C_ALU;
      7'b0000011:             dec_cls = C_LOAD;
      7'b0100011:             dec_cls = C_STORE;
      7'b1100011:             dec_cls = C_BRANCH;
      7'b1101111, 7'b1100111: dec_cls = C_JUMP;
      7'b1110011:             dec_cls = C_SYS;
      default:                dec_ok  = 1'b0;
    endcase
  end

  // TIMEOUT of 0 disables the bus watchdog entirely.
  assign to_expired = (TIMEOUT != 0) && (to_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ALU;
      br_q      <= 1'b0;
      to_q      <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      br_q      <= br_d;
      to_q      <= to_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    cls_d     = (state_q == S_DECODE) ? dec_cls : cls_q;
    br_d      = (state_q == S_EXEC) ? br_taken : br_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_rvalid) begin
          state_d = S_DECODE;
        end else if (to_expired) begin
          state_d   = S_FAULT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (!dec_ok) begin
          state_d   = S_FAULT;
          illegal_d = 1'b1;
        end else if (dec_cls == C_SYS && sys_imm12 == 12'h001) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_rvalid) begin
          state_d = S_WB;
        end else if (to_expired) begin
          state_d   = S_FAULT;
          bus_err_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = state_q;
    endcase

    // Wait counter restarts on every entry to a request state.
    if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
      to_d = '0;
    end else if (state_q == S_FETCH || state_q == S_MEM) begin
      to_d = to_q + TO_ONE;
    end else begin
      to_d = to_q;
    end
  end

  always_comb begin
    imem_req = (state_q == S_FETCH);
    inst_we  = (state_q == S_FETCH) && imem_rvalid;
    dmem_req = (state_q == S_MEM);
    dmem_wen = (state_q == S_MEM) && (cls_q == C_STORE);
    pc_we    = (state_q == S_WB);
    reg_we   = (state_q == S_WB) &&
               (cls_q == C_ALU || cls_q == C_LOAD || cls_q == C_JUMP);
    pc_sel   = (state_q == S_WB) &&
               (cls_q == C_JUMP || (cls_q == C_BRANCH && br_q));
    halt     = halt_q;
    illegal  = illegal_q;
    bus_err  = bus_err_q;
    state_o  = state_q;
  end

`ifdef SEQ_PERF_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 32'h0;
      ret_q <= 32'h0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT && state_q != S_FAULT)
        cyc_q <= cyc_q + 32'h1;
      if (state_q == S_WB)
        ret_q <= ret_q + 32'h1;
    end
  end

  assign perf_cycle   = cyc_q;
  assign perf_instret = ret_q;
`else
  assign perf_cycle   = 32'h0;
  assign perf_instret = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060170_seq_ctrl.sv
// ============================================================================
// Module   : tb_ysyx_25060170_seq_ctrl
// Brief    : Directed self-checking bench for the instruction sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25060170_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic        imem_rvalid;
  logic        inst_we;
  logic [6:0]  opcode;
  logic [11:0] sys_imm12;
  logic        br_taken;
  logic        dmem_req;
  logic        dmem_wen;
  logic        dmem_rvalid;
  logic        reg_we;
  logic        pc_we;
  logic        pc_sel;
  logic        halt;
  logic        illegal;
  logic        bus_err;
  logic [2:0]  state_o;
  logic [31:0] perf_cycle;
  logic [31:0] perf_instret;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OP_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  ysyx_25060170_seq_ctrl #(.TIMEOUT(8), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_rvalid(imem_rvalid), .inst_we(inst_we),
    .opcode(opcode), .sys_imm12(sys_imm12), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_rvalid(dmem_rvalid),
    .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halt(halt), .illegal(illegal), .bus_err(bus_err), .state_o(state_o),
    .perf_cycle(perf_cycle), .perf_instret(perf_instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Called just after the edge that entered FETCH; leaves the bench in DECODE.
  task automatic issue(input string tag, input logic [6:0] op, input logic [11:0] imm);
    imem_rvalid = 1'b1;
    opcode      = op;
    sys_imm12   = imm;
    smp();
    chk({tag, "_inst_we"}, 32'(inst_we), 32'd1);
    tick();
    imem_rvalid = 1'b0;
    smp();
    chk({tag, "_decode"}, 32'({state_o, inst_we}), 32'({3'd2, 1'b0}));
  endtask

  task automatic restart();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_rvalid = 1'b0; opcode = 7'd0;
    sys_imm12 = 12'd0; br_taken = 1'b0; dmem_rvalid = 1'b0;
    #3;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_strobes", 32'({imem_req, inst_we, dmem_req, dmem_wen, reg_we, pc_we, pc_sel}), 32'd0);
    chk("rst_flags", 32'({halt, illegal, bus_err}), 32'd0);
    chk("rst_perf", perf_cycle | perf_instret, 32'd0);

    // addi with fetch data one cycle late
    tick(); rst_n = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    smp();
    chk("fetch_wait", 32'({state_o, imem_req, inst_we}), 32'({3'd1, 1'b1, 1'b0}));
    tick();
    issue("addi", OP_ALU, 12'h000);
    tick(); smp();
    chk("addi_exec", 32'(state_o), 32'd3);
    tick(); smp();
    chk("addi_wb", 32'({state_o, reg_we, pc_we, pc_sel}), 32'({3'd5, 3'b110}));
    tick(); smp();
    chk("addi_refetch", 32'({state_o, imem_req}), 32'({3'd1, 1'b1}));

    // sw with dmem_rvalid three cycles late
    tick();
    issue("sw", OP_ST, 12'h000);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("sw_mem_wait", 32'({state_o, dmem_req, dmem_wen, imem_req}), 32'({3'd4, 3'b110}));
      tick();
    end
    dmem_rvalid = 1'b1;
    smp();
    chk("sw_mem_ack", 32'({state_o, dmem_req, dmem_wen}), 32'({3'd4, 2'b11}));
    tick(); dmem_rvalid = 1'b0; smp();
    chk("sw_wb", 32'({state_o, reg_we, pc_we, pc_sel}), 32'({3'd5, 3'b010}));

    // beq taken: br_taken sampled in EXEC, dropped in WB
    tick();
    issue("beq_t", OP_BR, 12'h000);
    tick(); br_taken = 1'b1; smp();
    tick(); br_taken = 1'b0; smp();
    chk("beq_t_wb", 32'({state_o, reg_we, pc_we, pc_sel}), 32'({3'd5, 3'b011}));

    // beq not taken: br_taken raised only in WB must not matter
    tick();
    issue("beq_n", OP_BR, 12'h000);
    tick(); br_taken = 1'b0; smp();
    tick(); br_taken = 1'b1; smp();
    chk("beq_n_wb", 32'({state_o, reg_we, pc_we, pc_sel}), 32'({3'd5, 3'b010}));
    br_taken = 1'b0;

    // jal
    tick();
    issue("jal", OP_JAL, 12'h000);
    tick(); tick(); smp();
    chk("jal_wb", 32'({state_o, reg_we, pc_we, pc_sel}), 32'({3'd5, 3'b111}));

    // lw with immediate data
    tick();
    issue("lw", OP_LD, 12'h000);
    tick(); tick(); dmem_rvalid = 1'b1; smp();
    chk("lw_mem", 32'({state_o, dmem_req, dmem_wen}), 32'({3'd4, 2'b10}));
    tick(); dmem_rvalid = 1'b0; smp();
    chk("lw_wb", 32'({state_o, reg_we, pc_we, pc_sel}), 32'({3'd5, 3'b110}));

    // ecall behaves as a NOP
    tick();
    issue("ecall", OP_SYS, 12'h000);
    tick(); smp();
    chk("ecall_exec", 32'(state_o), 32'd3);
    tick(); smp();
    chk("ecall_wb", 32'({state_o, reg_we, pc_we, pc_sel}), 32'({3'd5, 3'b010}));

    // ebreak halts; 7 instructions retired before it
    tick();
    issue("ebreak", OP_SYS, 12'h001);
    chk("ebreak_pre_halt", 32'(halt), 32'd0);
    tick(); smp();
    chk("ebreak_halt", 32'({state_o, halt, illegal, bus_err}), 32'({3'd6, 3'b100}));
    imem_rvalid = 1'b1; dmem_rvalid = 1'b1; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); smp();
      chk("halt_quiet", 32'({state_o, halt, imem_req, inst_we, dmem_req, reg_we, pc_we}),
          32'({3'd6, 1'b1, 5'b00000}));
    end
    imem_rvalid = 1'b0; dmem_rvalid = 1'b0; start = 1'b0;
`ifdef SEQ_PERF_EN
    chk("perf_instret", perf_instret, 32'd7);
`else
    chk("perf_tied", perf_cycle | perf_instret, 32'd0);
`endif

    // fetch timeout: 8 request cycles then FAULT with bus_err
    tick();
    rst_n = 1'b0; #1;
    chk("rst_clears_halt", 32'({state_o, halt}), 32'd0);
    restart();
    smp();
    chk("to_req1", 32'({state_o, imem_req}), 32'({3'd1, 1'b1}));
    for (int i = 2; i <= 8; i++) begin
      tick(); smp();
      chk("to_waiting", 32'({state_o, imem_req, bus_err}), 32'({3'd1, 2'b10}));
    end
    tick(); smp();
    chk("to_fault", 32'({state_o, imem_req, illegal, bus_err}), 32'({3'd7, 3'b001}));

    // illegal opcode
    tick();
    restart();
    issue("ill", 7'b0000000, 12'h000);
    tick(); smp();
    chk("ill_fault", 32'({state_o, halt, illegal, bus_err}), 32'({3'd7, 3'b010}));

    // reset mid-MEM drops dmem_req at once, then normal operation resumes
    tick();
    restart();
    issue("rstmem", OP_LD, 12'h000);
    tick(); tick(); smp();
    chk("rstmem_req", 32'({state_o, dmem_req}), 32'({3'd4, 1'b1}));
    #1 rst_n = 1'b0;
    #1;
    chk("rstmem_drop", 32'({state_o, dmem_req, reg_we, pc_we}), 32'd0);
    chk("rstmem_flags", 32'({halt, illegal, bus_err}), 32'd0);
    tick(); rst_n = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    issue("resume", OP_ALU, 12'h000);
    tick(); tick(); smp();
    chk("resume_wb", 32'({state_o, reg_we, pc_we, pc_sel}), 32'({3'd5, 3'b110}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
